// File: rtl/load_progress_if.sv
// Bus between the transfer/video side and the progress-bar feeder.
// master drives transfer status and vblank; slave returns the bar state.
interface load_progress_if #(
    parameter int WIDTH = 24
);
    logic             active;
    logic [WIDTH-1:0] pos;
    logic [WIDTH-1:0] size;
    logic             vblank;
    logic             enable;
    logic [6:0]       progress;
    logic             busy;

    modport master (
        output active, pos, size, vblank,
        input  enable, progress, busy
    );

    modport slave (
        input  active, pos, size, vblank,
        output enable, progress, busy
    );
endinterface

// File: rtl/load_progress.sv
// Progress-bar feeder: once per frame computes floor(128*pos/size), held at full after the transfer ends.
// Latency: result lands 8 clocks after the vblank latch edge; no backpressure, vblank rises during a divide are dropped.
// Optional: define PROGRESS_MONOTONIC_EN so the bar never shrinks within one transfer.
module load_progress #(
    parameter int WIDTH       = 24,
    parameter int HOLD_FRAMES = 50
) (
    input  logic            clk,
    input  logic            reset,
    load_progress_if.slave  bus
);
    localparam int HW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DIV, HOLD} state_t;
    typedef enum logic [1:0] {RES_DIV, RES_ZERO, RES_FULL} res_t;

    state_t           state_q, state_d;
    res_t             mode_q, mode_d;
    logic             vblank_d_q, active_d_q;
    logic             enable_q, enable_d;
    logic             busy_q, busy_d;
    logic [6:0]       progress_q, progress_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] size_q, size_d;
    logic [6:0]       quo_q, quo_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [HW-1:0]    hold_q, hold_d;

    logic             vrise, arise, afall, ge;
    logic [WIDTH:0]   r_shift;
    logic [6:0]       result;

    always_comb begin
        vrise   = bus.vblank & ~vblank_d_q;
        arise   = bus.active & ~active_d_q;
        afall   = ~bus.active & active_d_q;
        r_shift = r_q << 1;
        ge      = (r_shift >= {1'b0, size_q});

        case (mode_q)
            RES_ZERO: result = 7'd0;
            RES_FULL: result = 7'd127;
            default:  result = quo_q;
        endcase

        state_d    = state_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        progress_d = progress_q;
        r_d        = r_q;
        size_d     = size_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;

        // Transfer end beats any pending latch or divide step.
        if (afall && (state_q == WAIT || state_q == DIV)) begin
            progress_d = 7'd127;
            busy_d     = 1'b0;
            hold_d     = HW'(HOLD_FRAMES);
            state_d    = (HOLD_FRAMES == 0) ? IDLE : HOLD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arise) begin
                        progress_d = 7'd0;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (vrise) begin
                        if (bus.size == '0)
                            mode_d = RES_ZERO;
                        else if (bus.pos >= bus.size)
                            mode_d = RES_FULL;
                        else
                            mode_d = RES_DIV;
                        r_d     = {1'b0, bus.pos};
                        size_d  = bus.size;
                        quo_d   = 7'd0;
                        cnt_d   = 3'd0;
                        busy_d  = 1'b1;
                        state_d = DIV;
                    end
                end
                DIV: begin
                    if (cnt_q == 3'd7) begin
`ifdef PROGRESS_MONOTONIC_EN
                        progress_d = (result > progress_q) ? result : progress_q;
`else
                        progress_d = result;
`endif
                        busy_d  = 1'b0;
                        state_d = WAIT;
                    end else begin
                        r_d   = ge ? (r_shift - {1'b0, size_q}) : r_shift;
                        quo_d = {quo_q[5:0], ge};
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                HOLD: begin
                    if (arise) begin
                        progress_d = 7'd0;
                        state_d    = WAIT;
                    end else if (vrise) begin
                        if (hold_q <= HW'(1))
                            state_d = IDLE;
                        else
                            hold_d = hold_q - HW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        enable_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= RES_DIV;
            vblank_d_q <= 1'b0;
            active_d_q <= 1'b0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            progress_q <= 7'd0;
            r_q        <= '0;
            size_q     <= '0;
            quo_q      <= 7'd0;
            cnt_q      <= 3'd0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            vblank_d_q <= bus.vblank;
            active_d_q <= bus.active;
            enable_q   <= enable_d;
            busy_q     <= busy_d;
            progress_q <= progress_d;
            r_q        <= r_d;
            size_q     <= size_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
        end
    end

    assign bus.enable   = enable_q;
    assign bus.progress = progress_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_load_progress.sv
// Directed bench for load_progress with HOLD_FRAMES=3; expectations follow PROGRESS_MONOTONIC_EN if defined.
module tb_load_progress;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    load_progress_if #(.WIDTH(24)) bus ();

    load_progress #(.WIDTH(24), .HOLD_FRAMES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse vblank (latch edge E0) and advance to just after E7.
    task automatic frame_to_e7;
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        repeat (7) tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.active = 1'b0; bus.vblank = 1'b0; bus.pos = '0; bus.size = '0;
        tick(); tick();
        n_checks++; if (bus.enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got %0d want 0", bus.enable); end
        n_checks++; if (bus.progress !== 7'd0) begin n_fail++; $display("FAIL reset_progress got %0d want 0", bus.progress); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0d want 0", bus.busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        bus.active = 1'b1; bus.pos = 24'h001000; bus.size = 24'h002000;
        tick();
        n_checks++; if (bus.enable !== 1'b1) begin n_fail++; $display("FAIL basic_enable_arise got %0d want 1", bus.enable); end
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (bus.busy !== 1'b1 || bus.progress !== 7'd0) begin
                n_fail++; $display("FAIL basic_busy_window[%0d] busy=%0d prog=%0d want busy=1 prog=0", i, bus.busy, bus.progress);
            end
            if (i < 7) tick();
        end
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %0d want 0", bus.busy); end
        n_checks++; if (bus.progress !== 7'd64) begin n_fail++; $display("FAIL basic_progress got %0d want 64", bus.progress); end
        n_checks++; if (bus.enable !== 1'b1) begin n_fail++; $display("FAIL basic_enable got %0d want 1", bus.enable); end
    endtask

    task automatic test_clamps;
        logic [6:0] exp_zero;
`ifdef PROGRESS_MONOTONIC_EN
        exp_zero = 7'd127;
`else
        exp_zero = 7'd0;
`endif
        bus.pos = 24'h000800; bus.size = 24'h000800;
        frame_to_e7();
        n_checks++; if (bus.progress !== 7'd64 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL clamp_eq_e7 prog=%0d busy=%0d want 64/1", bus.progress, bus.busy); end
        tick();
        n_checks++; if (bus.progress !== 7'd127 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL clamp_eq prog=%0d busy=%0d want 127/0", bus.progress, bus.busy); end

        bus.pos = 24'h000900;
        frame_to_e7();
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL clamp_gt_e7 busy=%0d want 1", bus.busy); end
        tick();
        n_checks++; if (bus.progress !== 7'd127 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL clamp_gt prog=%0d busy=%0d want 127/0", bus.progress, bus.busy); end

        bus.size = 24'h000000;
        frame_to_e7();
        n_checks++; if (bus.progress !== 7'd127 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL clamp_zero_e7 prog=%0d busy=%0d want 127/1", bus.progress, bus.busy); end
        tick();
        n_checks++; if (bus.progress !== exp_zero || bus.busy !== 1'b0) begin n_fail++; $display("FAIL clamp_zero prog=%0d busy=%0d want %0d/0", bus.progress, bus.busy, exp_zero); end
    endtask

    task automatic test_abort_hold;
        bus.pos = 24'h001000; bus.size = 24'h002000;
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        tick(); tick();
        bus.active = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b0 || bus.progress !== 7'd127) begin n_fail++; $display("FAIL abort busy=%0d prog=%0d want 0/127", bus.busy, bus.progress); end
        n_checks++; if (bus.enable !== 1'b1) begin n_fail++; $display("FAIL abort_enable got %0d want 1", bus.enable); end
        for (int k = 1; k <= 3; k++) begin
            bus.vblank = 1'b1;
            tick();
            bus.vblank = 1'b0;
            tick();
            n_checks++;
            if (bus.enable !== ((k < 3) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL hold_enable[%0d] got %0d want %0d", k, bus.enable, (k < 3) ? 1 : 0);
            end
        end
        tick();
        n_checks++; if (bus.enable !== 1'b0 || bus.progress !== 7'd127) begin n_fail++; $display("FAIL hold_idle enable=%0d prog=%0d want 0/127", bus.enable, bus.progress); end
    endtask

    task automatic test_rearm_hold;
        bus.active = 1'b1;
        tick();
        bus.active = 1'b0;
        tick();
        n_checks++; if (bus.progress !== 7'd127 || bus.enable !== 1'b1) begin n_fail++; $display("FAIL rearm_hold prog=%0d en=%0d want 127/1", bus.progress, bus.enable); end
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        tick();
        bus.active = 1'b1;
        tick();
        n_checks++; if (bus.progress !== 7'd0 || bus.enable !== 1'b1) begin n_fail++; $display("FAIL rearm_arise prog=%0d en=%0d want 0/1", bus.progress, bus.enable); end
        bus.pos = 24'h000400; bus.size = 24'h001000;
        bus.vblank = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.vblank = 1'b0;
            n_checks++; if (bus.enable !== 1'b1) begin n_fail++; $display("FAIL rearm_enable[%0d] got %0d want 1", i, bus.enable); end
        end
        tick();
        n_checks++; if (bus.progress !== 7'd32) begin n_fail++; $display("FAIL rearm_progress got %0d want 32", bus.progress); end
    endtask

    task automatic test_monotonic;
        logic [6:0] exp_second;
`ifdef PROGRESS_MONOTONIC_EN
        exp_second = 7'd96;
`else
        exp_second = 7'd32;
`endif
        bus.pos = 24'h001800; bus.size = 24'h002000;
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        bus.pos = 24'h000800;
        repeat (7) tick();
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mono_first_e7 busy=%0d want 1", bus.busy); end
        tick();
        n_checks++; if (bus.progress !== 7'd96) begin n_fail++; $display("FAIL mono_first got %0d want 96", bus.progress); end
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        repeat (2) tick();
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        repeat (4) tick();
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mono_second_e7 busy=%0d want 1", bus.busy); end
        tick();
        n_checks++; if (bus.progress !== exp_second) begin n_fail++; $display("FAIL mono_second got %0d want %0d", bus.progress, exp_second); end
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL vrise_in_div_ignored busy=%0d want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_div;
        bus.pos = 24'h001000; bus.size = 24'h002000;
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        n_checks++; if (bus.enable !== 1'b0 || bus.progress !== 7'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset en=%0d prog=%0d busy=%0d want 0/0/0", bus.enable, bus.progress, bus.busy); end
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        tick();
        n_checks++; if (bus.progress !== 7'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_vblank prog=%0d busy=%0d want 0/0", bus.progress, bus.busy); end
        bus.vblank = 1'b1;
        reset = 1'b0;
        tick();
        bus.vblank = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_no_latch busy=%0d want 0", bus.busy); end
        repeat (8) tick();
        n_checks++; if (bus.progress !== 7'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_no_update prog=%0d busy=%0d want 0/0", bus.progress, bus.busy); end
        frame_to_e7();
        tick();
        n_checks++; if (bus.progress !== 7'd64) begin n_fail++; $display("FAIL post_reset_update got %0d want 64", bus.progress); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamps();
        test_abort_hold();
        test_rearm_hold();
        test_monotonic();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
